// File: rtl/wb_stage_pkg.sv
// Shared widths, encodings and the WB register payload for the writeback stage.
package wb_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 64;
  localparam int unsigned REG_W = 5;

  // Load size/sign encodings (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Writeback source select; 2'b11 falls back to the ALU result
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_reg_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Extracts the addressed byte/half from the loaded word and sign/zero-extends it.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select: half offset ignores off[0], no misalign handling here
  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = word[{off[1], 4'b0000} +: 16];
  end

  // Extension by load type; unknown funct3 passes the word through
  always_comb begin
    data_c = word;
    case (funct3)
      F3_LB:   data_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_c = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data_c = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_c = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   data_c = word;
      default: data_c = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback result mux and retired-instruction counter.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_word,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_write_data,
  output logic             wb_wr_en,
  output logic             wb_valid,
  output logic [CNT_W-1:0] instret
);

  logic [XLEN-1:0]  load_data;
  wb_reg_t          wb_d;
  wb_reg_t          wb_q;
  logic [CNT_W-1:0] instret_q;

  load_align u_load_align (
    .funct3 (mem_funct3),
    .off    (mem_alu_result[1:0]),
    .word   (mem_load_word),
    .data_c (load_data)
  );

  // Result mux and next WB payload; x0 writes are suppressed at capture
  always_comb begin
    wb_d       = '0;
    wb_d.valid = mem_valid;
    wb_d.wr_en = mem_valid & mem_reg_write & (mem_rd != REG_W'(0));
    wb_d.rd    = mem_rd;
    case (mem_wb_sel)
      WB_LOAD: wb_d.data = load_data;
      WB_PC4:  wb_d.data = mem_pc_plus4;
      default: wb_d.data = mem_alu_result;
    endcase
  end

  // WB register: flush inserts a zeroed bubble, stall holds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q <= '0;
    end else if (flush) begin
      wb_q <= '0;
    end else if (!stall) begin
      wb_q <= wb_d;
    end
  end

  // Count an instruction once, as it leaves WB unflushed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (wb_q.valid && !stall && !flush) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign wb_valid      = wb_q.valid;
  assign wb_wr_en      = wb_q.wr_en;
  assign wb_rd         = wb_q.rd;
  assign wb_write_data = wb_q.data;
  assign instret       = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected WB contents queued at drive, checked after the edge.
module tb_wb_stage;

  typedef struct {
    logic        valid;
    logic        wr_en;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_reg_write = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [1:0]  mem_wb_sel = '0;
  logic [2:0]  mem_funct3 = '0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_load_word = '0;
  logic [31:0] mem_pc_plus4 = '0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_write_data;
  logic        wb_wr_en;
  logic        wb_valid;
  logic [63:0] instret;

  int checks = 0;
  int failures = 0;

  exp_t        sb[$];
  exp_t        m_hold;
  logic        m_valid = 1'b0;
  logic [63:0] m_instret = '0;

  wb_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_load_word  (mem_load_word),
    .mem_pc_plus4   (mem_pc_plus4),
    .wb_rd          (wb_rd),
    .wb_write_data  (wb_write_data),
    .wb_wr_en       (wb_wr_en),
    .wb_valid       (wb_valid),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  // Drive one advancing MEM op, queue its expected WB contents, step one edge.
  task automatic issue(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] word,
                       input logic [31:0] pc4, input logic [31:0] exp_data);
    exp_t e;
    mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
    mem_funct3 = f3; mem_alu_result = alu; mem_load_word = word; mem_pc_plus4 = pc4;
    stall = 1'b0; flush = 1'b0;
    e.valid = v; e.wr_en = v & rw & (rd != 5'd0); e.rd = rd; e.data = exp_data;
    sb.push_back(e);
    m_hold = e;
    if (m_valid) m_instret = m_instret + 64'd1;
    m_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #3;
    checks++;
    if ({wb_valid, wb_wr_en, wb_rd, wb_write_data, instret} !== '0) begin
      failures++;
      $display("FAIL reset_init got v=%b we=%b rd=%0d d=%h ir=%0d want all 0",
               wb_valid, wb_wr_en, wb_rd, wb_write_data, instret);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu;
    exp_t e;
    issue(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF);
    e = sb.pop_front();
    checks++;
    if (wb_valid !== e.valid || wb_wr_en !== e.wr_en || wb_rd !== e.rd || wb_write_data !== e.data) begin
      failures++;
      $display("FAIL alu got v=%b we=%b rd=%0d d=%h want v=%b we=%b rd=%0d d=%h",
               wb_valid, wb_wr_en, wb_rd, wb_write_data, e.valid, e.wr_en, e.rd, e.data);
    end
    // 2'b11 behaves as ALU
    issue(1'b1, 1'b1, 5'd6, 2'b11, 3'b000, 32'h12345678, 32'hFFFFFFFF, 32'h4, 32'h12345678);
    e = sb.pop_front();
    checks++;
    if (wb_write_data !== e.data || wb_wr_en !== e.wr_en) begin
      failures++;
      $display("FAIL sel11 got we=%b d=%h want we=%b d=%h", wb_wr_en, wb_write_data, e.wr_en, e.data);
    end
  endtask

  task automatic test_load;
    logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b001, 3'b101};
    logic [1:0]  of [5] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd2};
    logic [31:0] ex [5] = '{32'hFFFFFFFF, 32'h00000080, 32'h00007F01, 32'hFFFF80FF, 32'h000080FF};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1'b1, 5'd10, 2'b01, f3[i], {30'h0400, of[i]}, 32'h80FF7F01, 32'h0, ex[i]);
      e = sb.pop_front();
      checks++;
      if (wb_write_data !== e.data || wb_wr_en !== e.wr_en) begin
        failures++;
        $display("FAIL load%0d f3=%0d off=%0d got d=%h we=%b want d=%h we=%b",
                 i, f3[i], of[i], wb_write_data, wb_wr_en, e.data, e.wr_en);
      end
    end
    // LW ignores offset
    issue(1'b1, 1'b1, 5'd11, 2'b01, 3'b010, 32'h00000403, 32'h80FF7F01, 32'h0, 32'h80FF7F01);
    e = sb.pop_front();
    checks++;
    if (wb_write_data !== e.data) begin
      failures++;
      $display("FAIL lw got d=%h want d=%h", wb_write_data, e.data);
    end
  endtask

  task automatic test_jal;
    exp_t e;
    issue(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h104, 32'h104);
    e = sb.pop_front();
    checks++;
    if (wb_write_data !== e.data || wb_wr_en !== e.wr_en || wb_rd !== e.rd) begin
      failures++;
      $display("FAIL jal got we=%b rd=%0d d=%h want we=%b rd=%0d d=%h",
               wb_wr_en, wb_rd, wb_write_data, e.wr_en, e.rd, e.data);
    end
    issue(1'b1, 1'b1, 5'd0, 2'b10, 3'b000, 32'h0, 32'h0, 32'h104, 32'h104);
    e = sb.pop_front();
    checks++;
    if (wb_wr_en !== 1'b0 || wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL jal_x0 got we=%b v=%b want we=0 v=1", wb_wr_en, wb_valid);
    end
    issue(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (instret !== m_instret || wb_valid !== e.valid) begin
      failures++;
      $display("FAIL jal_instret got ir=%0d v=%b want ir=%0d v=%b", instret, wb_valid, m_instret, e.valid);
    end
  endtask

  task automatic test_stall_flush;
    exp_t        e;
    logic [63:0] ir_before;
    issue(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 32'h00000055, 32'h0, 32'h0, 32'h00000055);
    e = sb.pop_front();
    checks++;
    if (wb_valid !== 1'b1 || wb_write_data !== e.data) begin
      failures++;
      $display("FAIL stall_entry got v=%b d=%h want v=1 d=%h", wb_valid, wb_write_data, e.data);
    end
    ir_before = m_instret;
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd9; mem_alu_result = 32'h99;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (wb_valid !== m_hold.valid || wb_rd !== m_hold.rd || wb_write_data !== m_hold.data ||
          wb_wr_en !== m_hold.wr_en || instret !== ir_before) begin
        failures++;
        $display("FAIL stall_hold%0d got v=%b rd=%0d d=%h ir=%0d want v=%b rd=%0d d=%h ir=%0d",
                 c, wb_valid, wb_rd, wb_write_data, instret, m_hold.valid, m_hold.rd, m_hold.data, ir_before);
      end
    end
    flush = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || wb_wr_en !== 1'b0 || instret !== m_instret) begin
      failures++;
      $display("FAIL flush got v=%b we=%b ir=%0d want v=0 we=0 ir=%0d", wb_valid, wb_wr_en, instret, m_instret);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_wrap;
    exp_t e;
    issue(1'b1, 1'b0, 5'd3, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0, 32'h1);
    e = sb.pop_front();
    stall = 1'b1;
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    checks++;
    if (instret !== m_instret) begin
      failures++;
      $display("FAIL wrap_preload got ir=%h want ir=%h", instret, m_instret);
    end
    @(negedge clk);
    issue(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (instret !== m_instret || m_instret !== 64'd0) begin
      failures++;
      $display("FAIL wrap got ir=%h want ir=%h", instret, m_instret);
    end
  endtask

  task automatic test_reset_midstream;
    exp_t e;
    issue(1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 32'hCAFEF00D, 32'h0, 32'h0, 32'hCAFEF00D);
    e = sb.pop_front();
    mem_valid = 1'b1;
    stall = 1'b1;
    #2;
    checks++;
    if (wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got v=%b want v=1", wb_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({wb_valid, wb_wr_en, wb_rd, wb_write_data, instret} !== '0) begin
      failures++;
      $display("FAIL rst_mid got v=%b we=%b rd=%0d d=%h ir=%0d want all 0",
               wb_valid, wb_wr_en, wb_rd, wb_write_data, instret);
    end
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; mem_valid = 1'b0;
    m_valid = 1'b0; m_instret = '0;
    @(posedge clk); #1;
    checks++;
    if (instret !== m_instret || wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_release got ir=%0d v=%b want ir=0 v=0", instret, wb_valid);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_jal();
    test_stall_flush();
    test_wrap();
    test_reset_midstream();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
